score_scanner: RTL
==================

SCORE_SCANNER -- requirements
Module: score_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (>=GUARD+2).
REQ-002 Parameter GUARD, default 4, anode-off cycles at the start of each slot (anti-ghosting).
REQ-003 Parameter BLINK_DIV, default 32, scan frames per blink half-period.
REQ-004 Parameter LEAD_BLANK, default 1, blank zero tens digits when 1.
REQ-005 clk  input  1  system clock.
REQ-006 Reset  input  1  reset Reset, asynchronous, active-high; clock clk.
REQ-007 PTen, POne, CTen, COne  input  4 each  BCD score digits from the score counter.
REQ-008 win  input  1  level, game-won flag from the score counter.
REQ-009 seg  output  7  cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 an  output  4  anodes, active-low, an[0]=COne, an[1]=CTen, an[2]=POne, an[3]=PTen.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Prescaler counts 0..REFRESH_DIV-1 and wraps; tick = prescaler at REFRESH_DIV-1.
REQ-013 2-bit digit index advances on tick, order 0,1,2,3, wraps 3->0; a 3->0 advance marks a frame boundary.
REQ-014 On each frame boundary, all four digits and win are captured into a snapshot in the same clock edge; display uses the snapshot only, so a frame is never a mix of old and new scores.
REQ-015 Guard counter loads GUARD on tick and decrements to 0; while nonzero, all anodes are off.
REQ-016 Decode: 0-9 standard 7-seg patterns (0=1000000, 1=1111001, 7=1111000, 8=0000000); values 10-15 show a dash (0111111).
REQ-017 When LEAD_BLANK=1 and snapshot tens digit (index 1 or 3) equals 0, that slot's anode stays off for the whole slot.
REQ-018 dp is 0 only while an[2] is driven (player/computer separator); otherwise 1.
REQ-019 Frame counter counts frame boundaries 0..BLINK_DIV-1, wraps; the blink phase bit toggles on each wrap.
REQ-020 When snapshot win=1 and blink phase=1, an=1111 and dp=1 for the whole frame; when snapshot win=0, blink phase has no effect.
REQ-021 seg, an, dp are registered: each reflects index, guard, snapshot and phase of the previous cycle (1-cycle latency).
REQ-022 seg always carries the decode of the current slot digit, even while the anode is off.
REQ-023 Exactly zero or one anode bit is 0 in any cycle.

Reset
REQ-024 Reset asserted, any cycle: prescaler, index, guard, frame counter, blink phase, snapshot (digits and win) clear to 0 immediately.
REQ-025 Reset asserted: an=1111, seg=1111111, dp=1 immediately, without waiting for clk.
REQ-026 After Reset deasserts, the first snapshot capture is the first frame boundary; until then, all-zero digits are displayed.

Verification (REFRESH_DIV=4, GUARD=1, BLINK_DIV=2, LEAD_BLANK=1)
REQ-027 Reset pulse mid-slot -> an=1111, seg=1111111, dp=1 asynchronously; scan restarts at index 0 with prescaler 0.
REQ-028 PTen=1, POne=1, CTen=0, COne=7, win=0, run 2 frames -> second frame: slot 0 an=1110 seg=1111000; slot 1 an=1111; slot 2 an=1011 seg=1111001 dp=0; slot 3 an=0111 seg=1111001; first cycle of each slot an=1111.
REQ-029 COne changes 3->4 during slot 2 -> slot 0 of the same frame already passed showing 3; the next frame shows 0011001 (4) in slot 0.
REQ-030 win=1 held, run 8 frames -> frames alternate 2 displayed / 2 fully blank (an=1111), seg still cycling.
REQ-031 COne=12 -> slot 0 seg=0111111 (dash); PTen=0 -> slot 3 anode stays 1111.
REQ-032 Check over all runs -> an never has more than one 0 bit; no anode is active in the first cycle of any slot.

Source files
------------

// File: rtl/score_scanner.sv
// score_scanner: time-multiplexed driver for a four-digit seven-segment
// score display (player tens/ones, computer tens/ones).
//
// A prescaler divides clk down to one digit slot every REFRESH_DIV cycles.
// Each slot starts with GUARD anode-off cycles to stop ghosting between
// digits. The scores are captured into a snapshot only at frame boundaries,
// so every frame shows one consistent score. When the captured win flag is
// set, whole frames blank in alternation at a rate set by BLINK_DIV.
//
// Ports
//   clk    in   system clock
//   Reset  in   asynchronous, active-high reset
//   PTen   in   [3:0] player tens digit (BCD)
//   POne   in   [3:0] player ones digit (BCD)
//   CTen   in   [3:0] computer tens digit (BCD)
//   COne   in   [3:0] computer ones digit (BCD)
//   win    in   game-won level flag
//   seg    out  [6:0] active-low cathodes, seg[6:0] = g,f,e,d,c,b,a
//   an     out  [3:0] active-low anodes, an[0]=COne .. an[3]=PTen
//   dp     out  active-low decimal point, lit with the an[2] digit
//
// Digit slot sequence
//   slot      | meaning
//   SLOT_CONE | computer ones, an[0]
//   SLOT_CTEN | computer tens, an[1], blankable when zero
//   SLOT_PONE | player ones,   an[2], decimal point lit
//   SLOT_PTEN | player tens,   an[3], blankable when zero
module score_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4,
  parameter int BLINK_DIV   = 32,
  parameter int LEAD_BLANK  = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] PTen,
  input  logic [3:0] POne,
  input  logic [3:0] CTen,
  input  logic [3:0] COne,
  input  logic       win,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    SLOT_CONE = 2'd0,
    SLOT_CTEN = 2'd1,
    SLOT_PONE = 2'd2,
    SLOT_PTEN = 2'd3
  } slot_e;

  logic [PW-1:0] presc_q;
  slot_e         slot_q;
  logic [GW-1:0] guard_q;
  logic [FW-1:0] frame_q;
  logic          phase_q;
  logic [3:0]    snap_pten_q;
  logic [3:0]    snap_pone_q;
  logic [3:0]    snap_cten_q;
  logic [3:0]    snap_cone_q;
  logic          snap_win_q;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          dp_q;

  logic          tick;
  logic          frame_end;
  logic [3:0]    digit;
  logic          slot_blank;
  logic          an_on;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b0111111; // non-BCD values show a dash
    endcase
    return p;
  endfunction

  assign tick      = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_end = tick && (slot_q == SLOT_PTEN);

  always_comb begin
    digit = snap_cone_q;
    case (slot_q)
      SLOT_CONE: digit = snap_cone_q;
      SLOT_CTEN: digit = snap_cten_q;
      SLOT_PONE: digit = snap_pone_q;
      SLOT_PTEN: digit = snap_pten_q;
      default:   digit = snap_cone_q;
    endcase
  end

  // Tens slots are the odd slot numbers.
  assign slot_blank = (LEAD_BLANK != 0) && slot_q[0] && (digit == 4'd0);
  assign an_on      = (guard_q == '0) && !slot_blank && !(snap_win_q && phase_q);
  assign seg_d      = seg_decode(digit);
  assign an_d       = an_on ? ~(4'b0001 << slot_q) : 4'b1111;
  assign dp_d       = ~(an_on && (slot_q == SLOT_PONE));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      presc_q     <= '0;
      slot_q      <= SLOT_CONE;
      guard_q     <= '0;
      frame_q     <= '0;
      phase_q     <= 1'b0;
      snap_pten_q <= 4'd0;
      snap_pone_q <= 4'd0;
      snap_cten_q <= 4'd0;
      snap_cone_q <= 4'd0;
      snap_win_q  <= 1'b0;
      seg_q       <= 7'b1111111;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);

      if (tick) begin
        slot_q  <= slot_e'(slot_q + 2'd1);
        guard_q <= GW'(GUARD);
      end else if (guard_q != '0) begin
        guard_q <= guard_q - GW'(1);
      end

      // Snapshot and blink bookkeeping share the frame-boundary edge so
      // the new frame starts with consistent digits, win flag and phase.
      if (frame_end) begin
        snap_pten_q <= PTen;
        snap_pone_q <= POne;
        snap_cten_q <= CTen;
        snap_cone_q <= COne;
        snap_win_q  <= win;
        if (frame_q == FW'(BLINK_DIV - 1)) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + FW'(1);
        end
      end

      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
